// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline controller and the CP0 vector logic.
package pipe_ctrl_pkg;

  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_TR   = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  localparam logic [31:0] VEC_INT = 32'h0000_0020;
  localparam logic [31:0] VEC_GEN = 32'h0000_0040;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } pipe_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline stages and the pipeline controller.
interface pipe_ctrl_if #(
  parameter int NSTAGE = 6,
  parameter int AW     = 32
);
  logic [NSTAGE-1:0] stallreq_i;
  logic [31:0]       excepttype_i;
  logic [AW-1:0]     cp0_epc_i;
  logic [NSTAGE-1:0] stall;
  logic              flush;
  logic [AW-1:0]     new_pc;
  logic              busy;
  logic              timeout;

  modport master (
    input  stallreq_i, excepttype_i, cp0_epc_i,
    output stall, flush, new_pc, busy, timeout
  );

  modport slave (
    output stallreq_i, excepttype_i, cp0_epc_i,
    input  stall, flush, new_pc, busy, timeout
  );
endinterface

// File: rtl/pipe_ctrl_exc_vector_dec.sv
// Maps a committed exception code to its redirect target; shared with CP0 for EPC/Cause update.
module exc_vector_dec
  import pipe_ctrl_pkg::*;
#(
  parameter int            AW       = 32,
  parameter logic [AW-1:0] EXC_BASE = '0
) (
  input  logic [31:0]   code_i,
  input  logic [AW-1:0] epc_i,
  output logic [AW-1:0] target_o
);

  always_comb begin
    target_o = '0;
    case (code_i)
      32'h0:    target_o = '0;
      EXC_INT:  target_o = EXC_BASE + AW'(VEC_INT);
      EXC_ERET: target_o = epc_i;
      EXC_SYS, EXC_RI, EXC_OV, EXC_TR:
                target_o = EXC_BASE + AW'(VEC_GEN);
      // unknown nonzero codes still get the general vector
      default:  target_o = EXC_BASE + AW'(VEC_GEN);
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall encoder, exception flush/redirect FSM and stall watchdog.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | inputs decoded combinationally: exception, watchdog or stalls
// S_FLUSH  | holding flush with latched target until hold counter expires
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int            NSTAGE       = 6,
  parameter int            AW           = 32,
  parameter logic [AW-1:0] EXC_BASE     = '0,
  parameter int            FLUSH_CYCLES = 1,
  parameter int            STALL_LIMIT  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  pipe_ctrl_if.master bus
);

  localparam logic [0:0] S_IDLE  = ST_IDLE;
  localparam logic [0:0] S_FLUSH = ST_FLUSH;

  localparam bit HOLD_EN = (FLUSH_CYCLES > 1);
  localparam bit WD_EN   = (STALL_LIMIT > 0);
  localparam int HW      = HOLD_EN ? $clog2(FLUSH_CYCLES) : 1;
  localparam int WW      = WD_EN ? $clog2(STALL_LIMIT + 1) : 1;

  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_EN ? FLUSH_CYCLES - 1 : 0);
  localparam logic [WW-1:0] WD_LAST   = WW'(WD_EN ? STALL_LIMIT - 1 : 0);
  localparam logic [WW-1:0] WD_MAX    = WW'(STALL_LIMIT);

  logic [0:0]        state_q, state_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [WW-1:0]     wd_q, wd_d;
  logic [AW-1:0]     pc_q, pc_d;

  logic [NSTAGE-1:0] stall_req;
  logic              exc_hit;
  logic              wd_fire;
  logic [31:0]       dec_code;
  logic [AW-1:0]     dec_pc;

  logic [NSTAGE-1:0] stall_o;
  logic              flush_o;
  logic [AW-1:0]     new_pc_o;
  logic              busy_o;
  logic              timeout_o;

  // Thermometer fill: every stage at or below the highest requester holds.
  always_comb begin
    logic acc;
    acc       = 1'b0;
    stall_req = '0;
    for (int i = NSTAGE - 1; i >= 1; i--) begin
      acc          = acc | bus.stallreq_i[i];
      stall_req[i] = acc;
    end
    stall_req[0] = acc;
  end

  assign exc_hit = |bus.excepttype_i;
  assign wd_fire = WD_EN && (state_q == S_IDLE) && !exc_hit &&
                   (|stall_req) && (wd_q == WD_LAST);

  // A watchdog recovery is redirected exactly like a general exception.
  assign dec_code = exc_hit ? bus.excepttype_i : (wd_fire ? EXC_SYS : 32'h0);

  exc_vector_dec #(
    .AW       (AW),
    .EXC_BASE (EXC_BASE)
  ) u_vec_dec (
    .code_i   (dec_code),
    .epc_i    (bus.cp0_epc_i),
    .target_o (dec_pc)
  );

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    wd_d      = wd_q;
    pc_d      = pc_q;
    stall_o   = '0;
    flush_o   = 1'b0;
    new_pc_o  = '0;
    busy_o    = 1'b0;
    timeout_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (exc_hit || wd_fire) begin
          flush_o   = 1'b1;
          new_pc_o  = dec_pc;
          timeout_o = wd_fire;
          wd_d      = '0;
          if (HOLD_EN) begin
            state_d = S_FLUSH;
            hold_d  = HOLD_LOAD;
            pc_d    = dec_pc;
          end
        end else if (|stall_req) begin
          stall_o = stall_req;
          if (WD_EN && (wd_q != WD_MAX)) wd_d = wd_q + WW'(1);
        end else begin
          wd_d = '0;
        end
      end

      S_FLUSH: begin
        flush_o  = 1'b1;
        new_pc_o = pc_q;
        busy_o   = 1'b1;
        wd_d     = '0;
        hold_d   = hold_q - HW'(1);
        if (hold_q == HW'(1)) state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        hold_d  = '0;
        wd_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      wd_q    <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      wd_q    <= wd_d;
      pc_q    <= pc_d;
    end
  end

  // Outputs are combinational from inputs, so reset must gate them directly.
  assign bus.stall   = rst_n ? stall_o   : '0;
  assign bus.flush   = rst_n ? flush_o   : 1'b0;
  assign bus.new_pc  = rst_n ? new_pc_o  : '0;
  assign bus.busy    = rst_n ? busy_o    : 1'b0;
  assign bus.timeout = rst_n ? timeout_o : 1'b0;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline controller for the MIPS core: it turns per-stage stall requests into a stall vector, turns a committed exception code into a flush plus redirect PC, and holds the flush for a configurable number of cycles. It also runs a stall watchdog that forces a recovery flush when the pipeline stays stalled for too long. It sits beside the pipeline and drives every stage register, the PC register and the CP0 redirect path. It supersedes the fixed 6-stage, two-requester controller.

## Interface
- NSTAGE, 6: number of stall bits; bit 0 = PC, bit k = stage-k pipeline register.
- AW, 32: PC/EPC width.
- EXC_BASE, 32'h0000_0000: exception vector base.
- FLUSH_CYCLES, 1: cycles flush stays asserted per exception, ≥1.
- STALL_LIMIT, 0: consecutive stalled cycles before watchdog fires; 0 disables it.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- stallreq_i  in  NSTAGE  bit k set = stage k requests a stall; bit 0 is ignored.
- excepttype_i  in  32  committed exception code; nonzero = exception this cycle.
- cp0_epc_i  in  AW  return address for ERET.
- stall  out  NSTAGE  per-stage hold.
- flush  out  1  flush all stage registers.
- new_pc  out  AW  redirect target, valid while flush=1.
- busy  out  1  controller is in its FLUSH hold state.
- timeout  out  1  one-cycle pulse when the watchdog fires.

## Operation
- States: IDLE and FLUSH. The FLUSH hold counter counts down from FLUSH_CYCLES-1.
- IDLE with excepttype_i≠0:
  - flush=1 and stall=0 in the same cycle (combinational).
  - new_pc is decoded from the code.
  - If FLUSH_CYCLES>1, latch new_pc and go to FLUSH.
- Vector decode:
  - Code 0x01 (interrupt) → EXC_BASE+0x20.
  - Codes 0x08, 0x0a, 0x0c, 0x0d → EXC_BASE+0x40.
  - Code 0x0e (ERET) → cp0_epc_i.
  - Any other nonzero code → EXC_BASE+0x40. Unknown codes are never left unredirected.
- FLUSH state:
  - flush=1, new_pc = latched value, stall=0, busy=1.
  - excepttype_i and stallreq_i are ignored; a new exception here is dropped.
  - When the hold counter reaches 0, return to IDLE.
- IDLE with no exception:
  - k = highest set index in stallreq_i[NSTAGE-1:1].
  - stall bits [k:0]=1, all higher bits 0. Example, NSTAGE=6: k=3 → 6'b001111, k=2 → 6'b000111.
  - No request → stall=0, flush=0, new_pc=0.
- Watchdog, active when STALL_LIMIT>0:
  - Counter increments each IDLE cycle with stall≠0.
  - It clears on any cycle with stall=0, on any exception, and in FLUSH.
  - When it reaches STALL_LIMIT: timeout=1 for one cycle, and that cycle behaves as an exception with target EXC_BASE+0x40 (flush=1, stall=0, FLUSH entry rules apply).
- Priority in IDLE: exception > watchdog > stall request.
- The watchdog counter is $clog2(STALL_LIMIT+1) bits wide and saturates; it never wraps.

## Timing
- While rst_n=0: stall=0, flush=0, new_pc=0, busy=0, timeout=0, state=IDLE, all counters 0. Outputs are forced regardless of inputs.
- Stall, flush, new_pc in IDLE: zero latency, combinational from inputs.
- flush stays high for exactly FLUSH_CYCLES consecutive cycles per accepted exception.
- busy is high for the last FLUSH_CYCLES-1 of those cycles.
- FLUSH_CYCLES=1: the block is purely combinational apart from the watchdog.
- The first IDLE cycle after FLUSH evaluates inputs normally. Back-to-back exceptions are therefore accepted with no gap cycle.
- Reset asserted mid-FLUSH returns to IDLE immediately, with no further flush cycles.

## Structure
- pipe_ctrl_pkg holds:
  - the exception code constants EXC_INT=0x01, EXC_SYS=0x08, EXC_RI=0x0a, EXC_OV=0x0c, EXC_TR=0x0d, EXC_ERET=0x0e;
  - the vector offsets VEC_INT=0x20, VEC_GEN=0x40;
  - the state enum.
- One sub-module, exc_vector_dec: purely combinational, mapping code, EXC_BASE and cp0_epc_i to a target. It is reused by CP0 for the EPC/Cause update.
- Top level contains the FSM, the hold counter, the watchdog and the stall encoder.

## Test plan
- Default params, stallreq_i=6'b001100 → stall=6'b001111, flush=0. Then stallreq_i=6'b000100 → stall=6'b000111.
- Default params, excepttype_i=0x0e, cp0_epc_i=0x1234, stallreq_i=6'b001000 → same cycle flush=1, new_pc=0x1234, stall=0. Next cycle with inputs clear, flush=0.
- FLUSH_CYCLES=3, EXC_BASE=0x8000_0000, excepttype_i=0x01 for one cycle → flush=1 for 3 cycles, new_pc=0x8000_0020 throughout, busy=1 on cycles 2–3. An exception 0x08 presented on cycle 2 is ignored.
- Unknown code 0x05 → flush=1, new_pc=EXC_BASE+0x40.
- STALL_LIMIT=4, stallreq_i held at 6'b000100 → timeout pulses on the 4th stalled cycle with flush=1, new_pc=0x40. With stalls continuing, the next timeout comes 4 stalled IDLE cycles later.
- rst_n dropped during cycle 2 of a 3-cycle flush → all outputs 0 immediately. After release, stall decodes from stallreq_i in the first cycle.
